// File: rtl/simon_keyslot_engine.sv
// simon_keyslot_engine: SLOTS-entry SIMON key store filled from a 32-bit TRNG stream,
// encrypting one block at a time under a selected slot with valid/ready handshakes.
module simon_core #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N*M-1:0] key,
    input  logic [2*N-1:0] pt,
    output logic           done,
    output logic [2*N-1:0] ct
);
    logic [N-1:0] x_q, x_d, y_q, y_d, tmp, tmp2, knew, f;
    logic [N-1:0] kw_q [M];
    logic [N-1:0] kw_d [M];
    logic [61:0]  z_q, z_d;
    logic [7:0]   rnd_q, rnd_d;
    logic         run_q, run_d;
    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction
    assign done = run_q && rnd_q == 8'(T);
    assign ct   = {x_q, y_q};
    always_comb begin
        tmp   = rol(kw_q[M-1], N - 3) ^ ((M == 4) ? kw_q[1] : '0);
        tmp2  = tmp ^ rol(tmp, N - 1);
        knew  = ~kw_q[0] ^ tmp2 ^ {{(N-2){1'b0}}, 2'b11} ^ {{(N-1){1'b0}}, z_q[61]};
        f     = (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2);
        x_d   = x_q;
        y_d   = y_q;
        kw_d  = kw_q;
        z_d   = z_q;
        rnd_d = rnd_q;
        run_d = run_q;
        if (!en) begin
            run_d = 1'b0;
        end else if (!run_q) begin
            run_d      = 1'b1;
            rnd_d      = '0;
            z_d        = Z;
            {x_d, y_d} = pt;
            for (int i = 0; i < M; i++) kw_d[i] = key[N*i +: N];
        end else if (!done) begin
            x_d = y_q ^ f ^ kw_q[0];
            y_d = x_q;
            for (int i = 0; i < M - 1; i++) kw_d[i] = kw_q[i+1];
            kw_d[M-1] = knew;
            z_d       = {z_q[60:0], z_q[61]};
            rnd_d     = rnd_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            for (int i = 0; i < M; i++) kw_q[i] <= '0;
            z_q   <= '0;
            rnd_q <= '0;
            run_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            kw_q  <= kw_d;
            z_q   <= z_d;
            rnd_q <= rnd_d;
            run_q <= run_d;
        end
    end
endmodule

module simon_keyslot_engine #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int SLOTS = 8,
    localparam int K = N * M,
    localparam int SW = $clog2(SLOTS),
    localparam int WPK = (K + 31) / 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rng_valid,
    input  logic [31:0]      rng_word,
    input  logic             gen_req,
    input  logic [SW-1:0]    gen_slot,
    output logic             gen_ack,
    input  logic             zero_req,
    input  logic [SW-1:0]    zero_slot,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [SW-1:0]    enc_slot,
    input  logic [2*N-1:0]   enc_pt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_ct,
    output logic             out_err,
    output logic [SLOTS-1:0] slot_valid,
    output logic             busy
);
    localparam int WCW = $clog2(WPK + 1);
    typedef enum logic [1:0] {IDLE, GEN, RUN, OUT} state_t;
    state_t            state_q, state_d;
    logic [K-1:0]      key_q [SLOTS];
    logic [K-1:0]      key_d [SLOTS];
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [32*WPK-1:0] shadow_q, shadow_d;
    logic [WCW-1:0]    wc_q, wc_d;
    logic [SW-1:0]     gslot_q, gslot_d;
    logic [2*N-1:0]    pt_q, pt_d, ct_q, ct_d, core_ct;
    logic [K-1:0]      ck_q, ck_d;
    logic              en_q, en_d, err_q, err_d, ack_q, ack_d, core_done;
    simon_core #(.N(N), .M(M)) u_core (
        .clk(clk), .rst(!rst_n), .en(en_q), .key(ck_q), .pt(pt_q), .done(core_done), .ct(core_ct)
    );
    assign enc_ready  = rst_n && state_q == IDLE && !zero_req && !gen_req;
    assign busy       = state_q != IDLE;
    assign out_valid  = state_q == OUT;
    assign out_ct     = ct_q;
    assign out_err    = err_q;
    assign gen_ack    = ack_q;
    assign slot_valid = valid_q;
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        valid_d  = valid_q;
        shadow_d = shadow_q;
        wc_d     = wc_q;
        gslot_d  = gslot_q;
        pt_d     = pt_q;
        ck_d     = ck_q;
        en_d     = en_q;
        ct_d     = ct_q;
        err_d    = err_q;
        ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (zero_req) begin
                    key_d[zero_slot]   = '0;
                    valid_d[zero_slot] = 1'b0;
                end else if (gen_req) begin
                    state_d = GEN;
                    gslot_d = gen_slot;
                    wc_d    = '0;
                end else if (enc_valid && valid_q[enc_slot]) begin
                    pt_d    = enc_pt;
                    ck_d    = key_q[enc_slot];
                    en_d    = 1'b1;
                    state_d = RUN;
                end else if (enc_valid) begin
                    err_d   = 1'b1;
                    ct_d    = '0;
                    state_d = OUT;
                end
            end
            GEN: begin
                if (rng_valid) begin
                    shadow_d[32*wc_q +: 32] = rng_word;
                    wc_d = wc_q + 1'b1;
                    if (wc_q == WCW'(WPK - 1)) begin
                        key_d[gslot_q]   = shadow_d[K-1:0];
                        valid_d[gslot_q] = 1'b1;
                        ack_d            = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    ct_d    = core_ct;
                    en_d    = 1'b0;
                    state_d = OUT;
                end
            end
            default: begin
                if (out_ready) begin
                    err_d   = 1'b0;
                    ct_d    = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            for (int i = 0; i < SLOTS; i++) key_q[i] <= '0;
            valid_q  <= '0;
            shadow_q <= '0;
            wc_q     <= '0;
            gslot_q  <= '0;
            pt_q     <= '0;
            ck_q     <= '0;
            en_q     <= 1'b0;
            ct_q     <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            shadow_q <= shadow_d;
            wc_q     <= wc_d;
            gslot_q  <= gslot_d;
            pt_q     <= pt_d;
            ck_q     <= ck_d;
            en_q     <= en_d;
            ct_q     <= ct_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
        end
    end
endmodule

// File: tb/tb_simon_keyslot_engine.sv
// tb_simon_keyslot_engine: randomized and directed checks against a transaction-level
// model of the slot store plus a plain SIMON32/64 reference.
module tb_simon_keyslot_engine;
    logic        clk = 1'b0;
    logic        rst_n, rng_valid, gen_req, zero_req, enc_valid, out_ready;
    logic [31:0] rng_word, enc_pt;
    logic [2:0]  gen_slot, zero_slot, enc_slot;
    logic        gen_ack, enc_ready, out_valid, out_err, busy;
    logic [31:0] out_ct;
    logic [7:0]  slot_valid;

    simon_keyslot_engine dut (
        .clk(clk), .rst_n(rst_n), .rng_valid(rng_valid), .rng_word(rng_word),
        .gen_req(gen_req), .gen_slot(gen_slot), .gen_ack(gen_ack),
        .zero_req(zero_req), .zero_slot(zero_slot),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_slot(enc_slot), .enc_pt(enc_pt),
        .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .out_err(out_err),
        .slot_valid(slot_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic        chk_en = 1'b0;
    logic [7:0]  m_valid;
    logic [63:0] m_key [8];
    logic        m_ack, m_err;
    logic [31:0] m_ct;
    int          phase;  // 0 idle, 1 generating, 2 encrypting, 3 result pending

    function automatic logic [15:0] rl(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [31:0] simon_enc(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rl(k[i-1], 13) ^ k[i-3];
            t = t ^ rl(t, 15);
            k[i] = ~k[i-4] ^ t ^ 16'(z[61-(i-4)]) ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("slot_valid", slot_valid, m_valid);
            chk("gen_ack", gen_ack, m_ack);
            chk("busy", busy, phase != 0);
            chk("enc_ready", enc_ready, rst_n && phase == 0 && !zero_req && !gen_req);
            if (phase != 2) chk("out_valid", out_valid, phase == 3);
            if (phase == 3) begin
                chk("out_ct", out_ct, m_ct);
                chk("out_err", out_err, m_err);
                if (m_err) chk("core_en_idle", dut.en_q, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = '0;
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_ct  = '0;
        phase = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic feed(input logic [31:0] w, input int maxgap);
        repeat ($urandom_range(maxgap)) begin
            rng_valid = 1'b0;
            rng_word  = $urandom;
            step();
        end
        rng_valid = 1'b1;
        rng_word  = w;
        step();
        rng_valid = 1'b0;
    endtask

    task automatic do_gen(input logic [2:0] s, input logic [31:0] w0, input logic [31:0] w1, input int maxgap);
        gen_req  = 1'b1;
        gen_slot = s;
        step();
        gen_req = 1'b0;
        phase   = 1;
        feed(w0, maxgap);
        feed(w1, maxgap);
        m_key[s]   = {w1, w0};
        m_valid[s] = 1'b1;
        m_ack      = 1'b1;
        phase      = 0;
    endtask

    task automatic do_zero(input logic [2:0] s);
        zero_req  = 1'b1;
        zero_slot = s;
        step();
        zero_req   = 1'b0;
        m_valid[s] = 1'b0;
        m_key[s]   = '0;
    endtask

    task automatic do_enc(input logic [2:0] s, input logic [31:0] pt, input int hold, input bit noise);
        int n;
        enc_valid = 1'b1;
        enc_slot  = s;
        enc_pt    = pt;
        step();
        enc_valid = 1'b0;
        if (m_valid[s]) begin
            m_ct  = simon_enc(m_key[s], pt);
            m_err = 1'b0;
            phase = 2;
            n = 0;
            while (!out_valid && n < 200) begin
                step();
                n++;
            end
            if (!out_valid) chk("run_timeout", 1'b1, 1'b0);
        end else begin
            m_ct  = '0;
            m_err = 1'b1;
        end
        phase = 3;
        repeat (hold) begin
            if (noise) begin
                gen_req   = 1'($urandom);
                zero_req  = 1'($urandom);
                gen_slot  = 3'($urandom);
                zero_slot = 3'($urandom);
            end
            step();
        end
        gen_req   = 1'b0;
        zero_req  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        phase     = 0;
        m_err     = 1'b0;
        m_ct      = '0;
    endtask

    initial begin
        rst_n = 1'b0; rng_valid = 1'b0; rng_word = '0; gen_req = 1'b0; gen_slot = '0;
        zero_req = 1'b0; zero_slot = '0; enc_valid = 1'b0; enc_slot = '0; enc_pt = '0; out_ready = 1'b0;
        model_reset();
        step();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_out_ct", out_ct, 32'h0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("model_vector", simon_enc(64'h1918111009080100, 32'h65656877), 32'hc69be9bb);

        do_gen(3'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 3);
        chk("slot_valid_after_gen3", slot_valid, 8'h08);
        do_enc(3'd3, 32'h65656877, 0, 1'b0);

        do_gen(3'd0, 32'h09080100, 32'h19181110, 2);
        do_enc(3'd0, 32'h65656877, 2, 1'b0);
        chk("known_vector_model", m_key[0], 64'h1918111009080100);

        do_enc(3'd5, 32'h12345678, 2, 1'b0);

        zero_req = 1'b1; zero_slot = 3'd3; gen_req = 1'b1; gen_slot = 3'd2;
        enc_valid = 1'b1; enc_slot = 3'd0; enc_pt = 32'h1;
        step();
        zero_req = 1'b0; gen_req = 1'b0; enc_valid = 1'b0;
        m_valid[3] = 1'b0; m_key[3] = '0;
        step();
        chk("triple_no_busy", busy, 1'b0);

        do_enc(3'd0, 32'hDEADBEEF, 10, 1'b1);

        gen_req = 1'b1; gen_slot = 3'd6;
        step();
        gen_req = 1'b0; phase = 1;
        feed(32'h11111111, 1);
        step();
        do_reset();
        step();
        chk("rst_gen_slot_valid", slot_valid, 8'h00);

        do_gen(3'd2, 32'hCAFEF00D, 32'h0BADBEEF, 1);
        enc_valid = 1'b1; enc_slot = 3'd2; enc_pt = 32'h55AA55AA;
        step();
        enc_valid = 1'b0; phase = 2;
        repeat (5) step();
        do_reset();
        step();
        chk("rst_run_out_valid", out_valid, 1'b0);

        do_gen(3'd1, 32'h01234567, 32'h89ABCDEF, 2);
        do_zero(3'd1);
        do_enc(3'd1, 32'h0F0F0F0F, 1, 1'b0);
        do_gen(3'd1, 32'hFEDCBA98, 32'h76543210, 2);
        chk("regen_slot1", slot_valid[1], 1'b1);
        do_enc(3'd1, 32'h0F0F0F0F, 1, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(3);
            if (op == 0) do_gen(3'($urandom), $urandom, $urandom, 3);
            else if (op == 1) do_zero(3'($urandom));
            else do_enc(3'($urandom), $urandom, $urandom_range(3), 1'b1);
            repeat ($urandom_range(2)) begin
                rng_valid = 1'($urandom);
                rng_word  = $urandom;
                step();
            end
            rng_valid = 1'b0;
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
